// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states and a byte-count helper.
// Sub-word support is selected with LSU_SUBWORD_EN.
package lsu_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    DONE
  } lsu_state_t;

  // Encoding 2'b11 is deliberately folded into the word case.
  function automatic logic [2:0] lsu_num_bytes(input logic [1:0] size);
    case (size)
      LSU_BYTE: lsu_num_bytes = 3'd1;
      LSU_HALF: lsu_num_bytes = 3'd2;
      default:  lsu_num_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and byte-memory port of the load/store unit.
// master = pipeline + memory side, slave = the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid_i;
  logic              req_write_i;
  logic [1:0]        req_size_i;
  logic              req_signed_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic              stall_o;
  logic              rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              misalign_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic [7:0]        mem_rdata_i;

  modport slave (
    input  req_valid_i, req_write_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
    input  mem_rdata_i,
    output stall_o, rsp_valid_o, rsp_rdata_o, misalign_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_write_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
    output mem_rdata_i,
    input  stall_o, rsp_valid_o, rsp_rdata_o, misalign_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_extend.sv
// Zero/sign extension of an assembled little-endian load word by access size.
// Only instantiated when LSU_SUBWORD_EN is defined.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (size_i)
      LSU_BYTE: data_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
      LSU_HALF: data_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle byte-serial load/store unit between EX/MEM and a byte-wide data memory.
// Define LSU_SUBWORD_EN for byte/halfword accesses with extension; otherwise every access is a word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  load_store_unit_if.slave  bus
);

  lsu_state_t        state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [31:0]       asm_q, asm_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [31:0]       ext_data;
  logic              accept, misaligned, xfer, capture;
  logic [1:0]        lane;

  assign accept = (state_q == IDLE) && bus.req_valid_i;
  assign xfer   = (state_q == XFER);
  // A read issued with byte index k returns one cycle later, when k has already advanced.
  assign capture = !write_q && ((xfer && (k_q != 3'd0)) || (state_q == DRAIN));
  assign lane    = k_q[1:0] - 2'd1;

`ifdef LSU_SUBWORD_EN
  logic [1:0] size_q, size_d;
  logic       signed_q, signed_d;

  always_comb begin
    case (bus.req_size_i)
      LSU_BYTE: misaligned = 1'b0;
      LSU_HALF: misaligned = bus.req_addr_i[0];
      default:  misaligned = (bus.req_addr_i[1:0] != 2'b00);
    endcase
  end

  lsu_extend u_extend (
    .data_i   (asm_d),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.req_size_i, bus.req_signed_i};
  assign misaligned = (bus.req_addr_i[1:0] != 2'b00);
  assign ext_data   = asm_d;
`endif

  always_comb begin
    asm_d = asm_q;
    if (accept) begin
      asm_d = '0;
    end else if (capture) begin
      asm_d[{lane, 3'b000} +: 8] = bus.mem_rdata_i;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rsp_valid_d = 1'b0;
    misalign_d  = 1'b0;
    rsp_rdata_d = '0;
`ifdef LSU_SUBWORD_EN
    size_d      = size_q;
    signed_d    = signed_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          addr_d     = bus.req_addr_i;
          wdata_d    = bus.req_wdata_i;
          write_d    = bus.req_write_i;
          k_d        = 3'd0;
          misalign_d = misaligned;
          state_d    = misaligned ? DONE : XFER;
`ifdef LSU_SUBWORD_EN
          size_d     = bus.req_size_i;
          signed_d   = bus.req_signed_i;
          n_d        = lsu_num_bytes(bus.req_size_i);
`else
          n_d        = 3'd4;
`endif
        end
      end
      XFER: begin
        k_d = k_q + 3'd1;
        if (k_q == n_q - 3'd1) begin
          state_d     = write_q ? DONE : DRAIN;
          rsp_valid_d = write_q;
        end
      end
      DRAIN: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ext_data;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the assembly register is reset too, so a reset mid-load never leaks stale bytes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
      state_q     <= IDLE;
      k_q         <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      asm_q       <= '0;
      rsp_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef LSU_SUBWORD_EN
      size_q      <= LSU_WORD;
      signed_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      asm_q       <= asm_d;
      rsp_valid_q <= rsp_valid_d;
      misalign_q  <= misalign_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_SUBWORD_EN
      size_q      <= size_d;
      signed_q    <= signed_d;
`endif
    end
  end

  // Stall is gated by reset so every output reads 0 while reset is held.
  assign bus.stall_o     = rst_i & (accept | xfer | (state_q == DRAIN));
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.misalign_o  = misalign_q;
  assign bus.mem_en_o    = xfer;
  assign bus.mem_we_o    = xfer & write_q;
  assign bus.mem_addr_o  = xfer ? addr_q + ADDR_W'(k_q) : '0;
  assign bus.mem_wdata_o = (xfer && write_q) ? wdata_q[{k_q[1:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-memory model, golden shadow memory and response scoreboard.
// Sub-word cases run only when LSU_SUBWORD_EN is defined.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;

  typedef struct packed {
    logic        mis;
    logic [31:0] rdata;
  } rsp_t;

  logic clk;
  logic rst_n;
  logic mem_init;
  logic [7:0] mem  [256];
  logic [7:0] gold [256];
  rsp_t exp_q[$];
  int n_checks;
  int n_errors;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: writes at the issue edge, read data registered for the following cycle.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
      bus.mem_rdata_i <= 8'h00;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_addr_o[7:0]] <= bus.mem_wdata_o;
      else              bus.mem_rdata_i <= mem[bus.mem_addr_o[7:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] eff_size(input logic [1:0] sz);
`ifdef LSU_SUBWORD_EN
    return sz;
`else
    return (sz == 2'b11) ? LSU_WORD : LSU_WORD | (sz & 2'b00);
`endif
  endfunction

  function automatic int num_bytes(input logic [1:0] sz);
    logic [1:0] es;
    es = eff_size(sz);
    if (es == 2'b00) return 1;
    if (es == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic is_mis(input logic [31:0] a, input logic [1:0] sz);
    int n;
    n = num_bytes(sz);
    if (n == 1) return 1'b0;
    if (n == 2) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] gold_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] w;
    int n;
    w = '0;
    n = num_bytes(sz);
    for (int i = 0; i < n; i++) w[8*i +: 8] = gold[a[7:0] + 8'(i)];
    if (n == 1) w = {{24{sg & w[7]}}, w[7:0]};
    else if (n == 2) w = {{16{sg & w[15]}}, w[15:0]};
    return w;
  endfunction

  // Response scoreboard: every rsp/misalign pulse must match the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && (bus.rsp_valid_o || bus.misalign_o)) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {62'd0, bus.rsp_valid_o, bus.misalign_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_flags", {62'd0, bus.rsp_valid_o, bus.misalign_o}, {62'd0, ~e.mis, e.mis});
        check("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(e.rdata));
      end
    end
  end

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int n, exp_done, cyc, en_cnt;
    logic mis;
    rsp_t e;
    n   = num_bytes(sz);
    mis = is_mis(a, sz);
    exp_done = mis ? 1 : (wr ? n + 1 : n + 2);
    @(negedge clk);
    bus.req_valid_i  = 1'b1;
    bus.req_write_i  = wr;
    bus.req_size_i   = sz;
    bus.req_signed_i = sg;
    bus.req_addr_i   = a;
    bus.req_wdata_i  = wd;
    e.mis   = mis;
    e.rdata = (wr || mis) ? 32'd0 : gold_load(a, sz, sg);
    exp_q.push_back(e);
    if (wr && !mis)
      for (int i = 0; i < n; i++) gold[a[7:0] + 8'(i)] = wd[8*i +: 8];
    #1;
    check({tag, "_stall0"}, 64'(bus.stall_o), 64'd1);
    cyc = 0;
    en_cnt = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
      if (bus.mem_en_o) begin
        check({tag, "_maddr"}, 64'(bus.mem_addr_o), 64'(a + 32'(en_cnt)));
        check({tag, "_mwe"}, 64'(bus.mem_we_o), 64'(wr));
        if (wr) check({tag, "_mwdata"}, 64'(bus.mem_wdata_o), 64'((wd >> (8 * en_cnt)) & 32'hFF));
        en_cnt++;
      end
    end while (bus.stall_o && cyc < 20);
    check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
    check({tag, "_mem_en_cnt"}, 64'(en_cnt), mis ? 64'd0 : 64'(n));
    bus.req_valid_i = 1'b0;
  endtask

  task automatic check_mem(input string tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) check(tag, 64'(mem[i]), 64'(gold[i]));
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {bus.stall_o, bus.rsp_valid_o, bus.misalign_o, bus.mem_en_o, bus.mem_we_o,
                bus.mem_wdata_o, 51'd0} | 64'(bus.mem_addr_o) | 64'(bus.rsp_rdata_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) gold[i] = 8'(i) ^ 8'hA5;
    rst_n            = 1'b0;
    mem_init         = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_write_i  = 1'b0;
    bus.req_size_i   = LSU_WORD;
    bus.req_signed_i = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_outputs");
    mem_init = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    do_req("st_word4", 1'b1, LSU_WORD, 1'b0, 32'd4, 32'hDEADBEEF);
    @(negedge clk);
    check_mem("mem_after_st_word4", 4, 7);
    check("mem4_ef", 64'(mem[4]), 64'hEF);
    do_req("ld_word4", 1'b0, LSU_WORD, 1'b0, 32'd4, 32'h0);
    do_req("ld_half5_mis", 1'b0, LSU_HALF, 1'b1, 32'd5, 32'h0);
    do_req("ld_word6_mis", 1'b0, LSU_WORD, 1'b0, 32'd6, 32'h0);
`ifdef LSU_SUBWORD_EN
    do_req("ld_byte7_s", 1'b0, LSU_BYTE, 1'b1, 32'd7, 32'h0);
    do_req("ld_byte7_u", 1'b0, LSU_BYTE, 1'b0, 32'd7, 32'h0);
    do_req("ld_half6_s", 1'b0, LSU_HALF, 1'b1, 32'd6, 32'h0);
    do_req("ld_half4_u", 1'b0, LSU_HALF, 1'b0, 32'd4, 32'h0);
    do_req("st_byte13", 1'b1, LSU_BYTE, 1'b0, 32'd13, 32'hCAFE0080);
    do_req("st_half14", 1'b1, LSU_HALF, 1'b0, 32'd14, 32'h1234F00D);
    do_req("ld_word12", 1'b0, 2'b11, 1'b1, 32'd12, 32'h0);
    do_req("ld_byte13_s", 1'b0, LSU_BYTE, 1'b1, 32'd13, 32'h0);
`else
    do_req("ld_bytesz4", 1'b0, LSU_BYTE, 1'b1, 32'd4, 32'h0);
    do_req("ld_bytesz5_mis", 1'b0, LSU_BYTE, 1'b0, 32'd5, 32'h0);
    do_req("st_halfsz12", 1'b1, LSU_HALF, 1'b1, 32'd12, 32'h80818283);
    do_req("ld_word12", 1'b0, 2'b11, 1'b0, 32'd12, 32'h0);
`endif
    do_req("ld_word_top", 1'b0, LSU_WORD, 1'b0, 32'hFFFF_FFFC, 32'h0);

    // Reset in cycle 3 of a word store: bytes 8 and 9 land, 10 and 11 must not.
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_size_i  = LSU_WORD;
    bus.req_addr_i  = 32'd8;
    bus.req_wdata_i = 32'h11223344;
    gold[8] = 8'h44;
    gold[9] = 8'h33;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midop_reset_outputs");
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_mem("mem_after_reset", 8, 11);
    do_req("ld_word8_post_rst", 1'b0, LSU_WORD, 1'b0, 32'd8, 32'h0);

    for (int it = 0; it < 24; it++) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(0, 15) * 4) + (($urandom_range(0, 5) == 0) ? 32'd2 : 32'd0)
           + ((it % 5 == 0) ? 32'd1 : 32'd0);
      do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ra, $urandom);
    end
    @(negedge clk);
    check_mem("mem_final", 0, 71);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the EX/MEM pipeline register and a byte-organised data memory. It turns one pipeline load/store request into a sequence of single-byte memory accesses, little-endian. It assembles load data with zero- or sign-extension and holds the pipeline with `stall_o` until the access completes. It replaces hard-wired word-only memory accesses with a sized, alignment-checked, multi-cycle port.

## Interface
- `ADDR_W`, 32, width of request and memory addresses
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  asynchronous, active-low reset
- `req_valid_i`  in  1  pipeline presents an access; held stable while `stall_o`=1
- `req_write_i`  in  1  1 = store, 0 = load
- `req_size_i`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- `req_signed_i`  in  1  sign-extend sub-word loads
- `req_addr_i`  in  ADDR_W  byte address
- `req_wdata_i`  in  32  store data; the low bytes are used for sub-word stores
- `stall_o`  out  1  freeze the pipeline
- `rsp_valid_o`  out  1  one-cycle pulse: load data valid or store complete
- `rsp_rdata_o`  out  32  extended load data; 0 for stores
- `misalign_o`  out  1  one-cycle pulse: the request was rejected as misaligned
- `mem_en_o`, `mem_we_o`  out  1 each  byte access strobe and write enable
- `mem_addr_o`  out  ADDR_W  byte address
- `mem_wdata_o`  out  8  write byte
- `mem_rdata_i`  in  8  read byte, valid in the cycle after its read issue cycle

## Operation
- FSM states: IDLE, XFER, DRAIN, DONE.
- **IDLE**
  - On `req_valid_i`=1: latch the request, set N = 1, 2 or 4 bytes, set byte counter k = 0.
  - Aligned request: go to XFER.
  - Misaligned request (half with `addr[0]`=1, word with `addr[1:0]`≠0): go to DONE with the misalign flag set. No memory access is made.
- **XFER**
  - Each cycle issues byte k: `mem_en_o`=1, `mem_addr_o`=addr+k, `mem_we_o`=write.
  - For stores, `mem_wdata_o` = wdata[8k+7:8k].
  - k increments each cycle.
  - After byte N−1: stores go to DONE, loads go to DRAIN.
- **Load capture**
  - The byte arriving on `mem_rdata_i` is captured into lane k−1 of the assembly register at the end of each cycle following a read issue.
  - DRAIN captures the last byte, then goes to DONE.
- **DONE**
  - Registered outputs are valid this cycle: `rsp_valid_o`=1, or `misalign_o`=1 for a rejected request.
  - `req_valid_i` is ignored.
  - Next state is always IDLE.
- **Extension**
  - Byte loads: bits [31:8] = bit 7 if signed, else 0.
  - Half loads: bits [31:16] = bit 15 if signed, else 0.
  - Word loads: no extension.
- Address arithmetic is modulo 2^ADDR_W; there is no range check.

## Timing
- `stall_o` = (IDLE & `req_valid_i`) | XFER | DRAIN. It is combinational and low in DONE.
- The pipeline therefore advances at the end of DONE.
- Cycle 0 is the IDLE acceptance cycle.
  - Store of N bytes: issues in cycles 1..N; DONE in cycle N+1.
  - Load of N bytes: issues in cycles 1..N; DRAIN in cycle N+1; DONE in cycle N+2.
  - Misaligned request: DONE in cycle 1; stall lasts 1 cycle.
- Back-to-back requests: a new request can be accepted in the IDLE cycle immediately after DONE.
- Reset (asynchronous, mid-operation allowed):
  - State returns to IDLE; every output is 0, including `rsp_rdata_o` and the assembly register.
  - Bytes already written stay written; there is no rollback.

## Configuration
- `LSU_SUBWORD_EN` defined: byte and halfword accesses and extension are supported as described above.
- `LSU_SUBWORD_EN` undefined:
  - `req_size_i` and `req_signed_i` are ignored.
  - Every access is a 4-byte word.
  - The misalign check is `addr[1:0]`≠0.
  - The extension logic is absent.

## Structure
- Package `lsu_pkg`:
  - Size encodings `LSU_BYTE`, `LSU_HALF`, `LSU_WORD`.
  - State enum `lsu_state_t`.
  - Byte-count helper function.
- One sub-module, `lsu_extend`: combinational size/sign extension of the assembled word. It is instantiated only under `LSU_SUBWORD_EN`.

## Test plan
- Store word `0xDEADBEEF` @4 → memory bytes 4..7 = EF, BE, AD, DE; `stall_o` high in cycles 0–4; `rsp_valid_o` in cycle 5.
- Load word @4 after the above → `rsp_rdata_o`=`0xDEADBEEF` in cycle 6; `stall_o` low in cycle 6 only.
- Load byte @7: signed → `0xFFFFFFDE`; unsigned → `0x000000DE`. Load half signed @6 → `0xFFFFDEAD`.
- Half load @5 → `misalign_o` pulse in cycle 1; `mem_en_o` never asserted; `rsp_valid_o`=0.
- Word store `0x11223344` @8, reset asserted in cycle 3 → bytes 8, 9 = 44, 33, bytes 10, 11 unchanged; all outputs 0; the next request is accepted normally.
- `LSU_SUBWORD_EN` undefined: byte-size load @4 → behaves as a word load returning `0xDEADBEEF`.
